// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared encodings and default widths for the multi-port register file
package reg_file_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read, write and clear signal bundle of the register file
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic                    wa_en;
    logic [ADDR_W-1:0]       wa_addr;
    logic [DATA_W-1:0]       wa_data;
    logic                    wb_en;
    logic [ADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic                    clr_req;
    logic                    clr_busy;
    logic                    clr_done;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, clr_req,
        input  rd_data, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, clr_req,
        output rd_data, clr_busy, clr_done
    );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with write bypass and hardwired zero entry
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = mem[addr];
        // Port B is checked last so it wins when both writers hit this address.
        if (BYPASS != 0) begin
            if (wa_en && (wa_addr == addr)) data = wa_data;
            if (wb_en && (wb_addr == addr)) data = wb_data;
        end
        if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - dual-write, NREAD-read register file with sequential bulk-clear engine
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    rf_state_e         state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [NREAD*DATA_W-1:0] rd_data_pk;

    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                mem_d[cnt_q[ADDR_W-1:0]] = '0;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Writes land after the clear step so a write to the entry being cleared survives.
        if (bus.wa_en) mem_d[bus.wa_addr] = bus.wa_data;
        if (bus.wb_en) mem_d[bus.wb_addr] = bus.wb_data;
        if (ZERO_REG != 0) mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .addr   (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .mem    (mem_q),
            .wa_en  (bus.wa_en),
            .wa_addr(bus.wa_addr),
            .wa_data(bus.wa_data),
            .wb_en  (bus.wb_en),
            .wb_addr(bus.wb_addr),
            .wb_data(bus.wb_data),
            .data   (rd_data_pk[i*DATA_W +: DATA_W])
        );
    end

    assign bus.rd_data  = rd_data_pk;
    assign bus.clr_busy = (state_q == ST_CLEAR);
    assign bus.clr_done = done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp (bypass/zero-reg and plain variants)
module tb_reg_file_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) if_a ();
    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) if_b ();

    assign if_b.rd_addr = if_a.rd_addr;
    assign if_b.wa_en   = if_a.wa_en;
    assign if_b.wa_addr = if_a.wa_addr;
    assign if_b.wa_data = if_a.wa_data;
    assign if_b.wb_en   = if_a.wb_en;
    assign if_b.wb_addr = if_a.wb_addr;
    assign if_b.wb_data = if_a.wb_data;
    assign if_b.clr_req = if_a.clr_req;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_a.slave)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_b.slave)
    );

    // Reference: plain arrays plus "which entry is the clear sweep on" (-1 = idle).
    logic [DW-1:0] ma [DEPTH];
    logic [DW-1:0] mb [DEPTH];
    int            clr_pos;
    logic          done_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ma[i] <= '0;
                mb[i] <= '0;
            end
            clr_pos <= -1;
            done_m  <= 1'b0;
        end else begin
            if (clr_pos >= 0) begin
                ma[clr_pos] <= '0;
                mb[clr_pos] <= '0;
            end
            if (if_a.wa_en) begin
                ma[if_a.wa_addr] <= if_a.wa_data;
                mb[if_a.wa_addr] <= if_a.wa_data;
            end
            if (if_a.wb_en) begin
                ma[if_a.wb_addr] <= if_a.wb_data;
                mb[if_a.wb_addr] <= if_a.wb_data;
            end
            ma[0]  <= '0;
            done_m <= (clr_pos == DEPTH - 1);
            if (clr_pos == DEPTH - 1)  clr_pos <= -1;
            else if (clr_pos >= 0)     clr_pos <= clr_pos + 1;
            else if (if_a.clr_req)     clr_pos <= 0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // feat=1: variant with bypass and hardwired zero entry; feat=0: neither.
    function automatic logic [DW-1:0] exp_rd(input bit feat, input logic [AW-1:0] ad,
                                             input logic [DW-1:0] stored);
        logic [DW-1:0] r;
        r = stored;
        if (feat && if_a.wa_en && if_a.wa_addr == ad) r = if_a.wa_data;
        if (feat && if_a.wb_en && if_a.wb_addr == ad) r = if_a.wb_data;
        if (feat && ad == '0) r = '0;
        return r;
    endfunction

    task automatic check_model(input string tag);
        logic [AW-1:0] ad;
        for (int i = 0; i < NR; i++) begin
            ad = if_a.rd_addr[i*AW +: AW];
            chk({tag, "_rd_a"}, if_a.rd_data[i*DW +: DW], exp_rd(1'b1, ad, ma[ad]));
            chk({tag, "_rd_b"}, if_b.rd_data[i*DW +: DW], exp_rd(1'b0, ad, mb[ad]));
        end
        chk({tag, "_busy_a"}, DW'(if_a.clr_busy), DW'(clr_pos >= 0));
        chk({tag, "_busy_b"}, DW'(if_b.clr_busy), DW'(clr_pos >= 0));
        chk({tag, "_done_a"}, DW'(if_a.clr_done), DW'(done_m));
        chk({tag, "_done_b"}, DW'(if_b.clr_done), DW'(done_m));
    endtask

    task automatic set_wr(input bit ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input bit be, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        if_a.wa_en = ae; if_a.wa_addr = aa; if_a.wa_data = ad;
        if_a.wb_en = be; if_a.wb_addr = ba; if_a.wb_data = bd;
    endtask

    task automatic set_rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        if_a.rd_addr = {r1, r0};
    endtask

    typedef struct {
        bit            wa_en;
        logic [AW-1:0] wa_addr;
        logic [DW-1:0] wa_data;
        bit            wb_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic [AW-1:0] r0, r1;
        logic [DW-1:0] a0, a1, b0, b1;
    } vec_t;

    vec_t vt [12];

    initial begin
        int busy_n, done_n, done_at;

        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vt[2]  = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
        vt[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h22222222, 32'h0,        32'h22222222};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vt[6]  = '{1'b1, 5'd9,  32'h12345678, 1'b1, 5'd10, 32'h9ABCDEF0, 5'd9,  5'd10, 32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h0};
        vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd9,  32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678};
        vt[8]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd0,  32'h55,       5'd3,  5'd0,  32'h33,       32'h0,        32'h0,        32'hFFFFFFFF};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd3,  32'h0,        32'h33,       32'h55,       32'h33};
        vt[10] = '{1'b1, 5'd31, 32'hAAAA5555, 1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hAAAA5555, 32'hAAAA5555, 32'h0,        32'h0};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hAAAA5555, 32'h0,        32'hAAAA5555, 32'h55};

        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        set_rd(5'd0, 5'd31);
        if_a.clr_req = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check_model("reset");
        chk("reset_rd_a1", if_a.rd_data[DW +: DW], 32'h0);
        chk("reset_busy",  DW'(if_a.clr_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_wr(vt[i].wa_en, vt[i].wa_addr, vt[i].wa_data, vt[i].wb_en, vt[i].wb_addr, vt[i].wb_data);
            set_rd(vt[i].r0, vt[i].r1);
            #1;
            chk($sformatf("vec%0d_a0", i), if_a.rd_data[0  +: DW], vt[i].a0);
            chk($sformatf("vec%0d_a1", i), if_a.rd_data[DW +: DW], vt[i].a1);
            chk($sformatf("vec%0d_b0", i), if_b.rd_data[0  +: DW], vt[i].b0);
            chk($sformatf("vec%0d_b1", i), if_b.rd_data[DW +: DW], vt[i].b1);
        end

        // Async reset asserted mid-cycle with the file populated
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            set_wr(1'b1, AW'(i), DW'(i) | 32'h100, 1'b0, '0, '0);
        end
        @(negedge clk);
        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        set_rd(5'd5, 5'd31);
        #1;
        chk("prerst_rd5", if_a.rd_data[0 +: DW], 32'h105);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_a0", if_a.rd_data[0  +: DW], 32'h0);
        chk("rst_async_a1", if_a.rd_data[DW +: DW], 32'h0);
        chk("rst_async_b0", if_b.rd_data[0  +: DW], 32'h0);
        chk("rst_async_b1", if_b.rd_data[DW +: DW], 32'h0);
        chk("rst_async_busy", DW'(if_a.clr_busy), 32'h0);
        chk("rst_async_done", DW'(if_a.clr_done), 32'h0);
        for (int i = 0; i < DEPTH; i += 2) begin
            @(negedge clk);
            set_rd(AW'(i), AW'(i + 1));
            #1;
            check_model("rst_sweep");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Bulk clear with writes racing the sweep
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            set_wr(1'b1, AW'(i), DW'(i), 1'b0, '0, '0);
        end
        @(negedge clk);
        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        set_rd(5'd3, 5'd20);
        if_a.clr_req = 1'b1;
        #1;
        chk("clr_idle_busy", DW'(if_a.clr_busy), 32'h0);
        busy_n = 0; done_n = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if_a.clr_req = 1'b0;
            if (k == 4) set_wr(1'b1, 5'd3, 32'hABCD, 1'b1, 5'd20, 32'hEEEE);
            else        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
            #1;
            check_model("clr_run");
            if (if_a.clr_busy) busy_n++;
            if (if_a.clr_done) begin done_n++; done_at = k; end
        end
        chk("clr_busy_cycles", DW'(busy_n), 32'd32);
        chk("clr_done_cycle",  DW'(done_at), 32'd33);
        chk("clr_done_count",  DW'(done_n), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            set_rd(AW'(i), AW'(i));
            #1;
            chk($sformatf("post_clr_a_r%0d", i), if_a.rd_data[0 +: DW], (i == 3) ? 32'hABCD : 32'h0);
            chk($sformatf("post_clr_b_r%0d", i), if_b.rd_data[0 +: DW], (i == 3) ? 32'hABCD : 32'h0);
        end

        // Reset in the middle of a clear
        for (int i = 8; i < 16; i++) begin
            @(negedge clk);
            set_wr(1'b1, AW'(i), DW'(i) | 32'h200, 1'b0, '0, '0);
        end
        @(negedge clk);
        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        set_rd(5'd11, 5'd12);
        if_a.clr_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if_a.clr_req = 1'b0;
            #1;
            check_model("mid_run");
            if (k == 11) begin
                chk("mid_busy_before", DW'(if_a.clr_busy), 32'h1);
                chk("mid_r11_live", if_a.rd_data[0 +: DW], 32'h20B);
                #1 rst_n = 1'b0;
                #1;
                chk("mid_busy_after", DW'(if_a.clr_busy), 32'h0);
                chk("mid_done_after", DW'(if_a.clr_done), 32'h0);
                chk("mid_rd_a0", if_a.rd_data[0  +: DW], 32'h0);
                chk("mid_rd_b1", if_b.rd_data[DW +: DW], 32'h0);
                break;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (if_a.clr_done || if_b.clr_done) done_n++;
        end
        chk("mid_no_done", DW'(done_n), 32'd0);

        // Fresh clear with clr_req held: full length, then immediate restart
        @(negedge clk);
        if_a.clr_req = 1'b1;
        busy_n = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k >= 34) if_a.clr_req = 1'b0;
            #1;
            check_model("hold_run");
            if (k <= 33 && if_a.clr_busy) busy_n++;
            if (if_a.clr_done && done_at == 0) done_at = k;
            if (k == 34) chk("hold_restart_busy", DW'(if_a.clr_busy), 32'h1);
        end
        chk("hold_busy_cycles", DW'(busy_n), 32'd32);
        chk("hold_done_cycle",  DW'(done_at), 32'd33);

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            set_wr(1'($urandom_range(0, 1)), AW'($urandom_range(0, (n % 2) ? 31 : 7)), DW'($urandom),
                   1'($urandom_range(0, 1)), AW'($urandom_range(0, (n % 3) ? 31 : 7)), DW'($urandom));
            set_rd(AW'($urandom_range(0, 31)), AW'($urandom_range(0, (n % 2) ? 7 : 31)));
            if_a.clr_req = ($urandom_range(0, 49) == 0);
            #1;
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
